ifetch_byte_reader: RTL
=======================

// Module: ifetch_byte_reader
// PURPOSE
// Per-thread instruction fetch front end: reads the byte-wide L3 memory port, assembles 32-bit
// little-endian instruction words (byte at PC in bits [7:0]), and hands {pc, inst} to the thread
// decoder through a small FIFO. It is the read side of the L3 program image written at load time.
// One instance per hardware thread.
// PARAMETERS
// AW        16   byte-address width of L3; PC is AW bits and wraps modulo 2**AW
// RESET_PC  0    PC loaded on reset
// FIFO_D    2    output FIFO depth in instructions; power of two, >= 2
// PORTS
// clk           in   1   core clock, all state on posedge
// rst           in   1   asynchronous, active-high reset
// enable        in   1   thread enable; fetch starts only while high
// redir_valid   in   1   redirect request (branch or restart)
// redir_pc      in   AW  redirect target
// mem_req       out  1   one-byte read request, held until mem_gnt
// mem_addr      out  AW  byte address of the request
// mem_gnt       in   1   request accepted this cycle
// mem_rvalid    in   1   read data valid; one response per grant, in order, latency >= 1
// mem_rdata     in   8   read byte
// inst_valid    out  1   FIFO head valid
// inst_ready    in   1   decoder accepts head on valid && ready
// inst_word     out  32  assembled instruction
// inst_pc       out  AW  address of byte 0 of inst_word
// fault         out  1   sticky misaligned-PC flag
// BEHAVIOUR
// - Reset values: mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst_word=0, inst_pc=0, fault=0.
//   Internal state: pc=RESET_PC, byte count=0, FIFO empty, discard=0, state=IDLE.
// - FSM states: IDLE, REQ, WAIT, HALT.
//   IDLE -> REQ when enable && FIFO has a free slot && !fault.
//   REQ: mem_req=1, mem_addr=pc+cnt. On mem_gnt -> WAIT.
//   WAIT: on mem_rvalid, write byte into lane cnt of the assembly register.
//     cnt<3: cnt++, go to REQ.
//     cnt==3: push {pc, word} into the FIFO, pc+=4 (wraps), cnt=0, go to IDLE.
//   Only one byte is outstanding. Each 4-byte word costs at least 8 cycles at latency 1.
// - Push and pop in the same cycle are legal when the FIFO is full. The free-slot check is made in
//   IDLE only, so a word in assembly always has a slot when it completes.
// - Dropping enable stops new words at IDLE only. A word already in assembly completes.
// - Redirect, any state (highest priority):
//   - Flush the FIFO; inst_valid=0 on the next cycle.
//   - Set pc=redir_pc and cnt=0; clear fault.
//   - If redir_pc[1:0]!=0: set fault and go to HALT.
//   - A redirect in WAIT sets discard=1. The next mem_rvalid is dropped and clears discard.
//     No new mem_req is issued while discard is set.
//   - A redirect in REQ withdraws mem_req the next cycle. The withdrawal is legal only if
//     mem_gnt was not seen in that same cycle. If mem_gnt was seen, treat it as the WAIT case.
// - HALT: no requests. Leave HALT only on a redirect to an aligned PC.
// - Redirect and pop in the same cycle: the flush wins and the pop is ignored.
// - Reset mid-operation clears everything asynchronously, including discard. The memory
//   side is reset by the same rst, so no stale response survives.
// - mem_rvalid outside WAIT with discard=0 is a protocol error: the byte is ignored.
// STRUCTURE
// - Shared core package:
//   - INST_W=32 and the instruction field slices: [3:0] class, [9:4] rd, [15:10] rs,
//     [19:16] func, [31:20] imm12.
//   - The fetch FSM state enum.
// - One sub-module: ifetch_fifo (parameterised DEPTH/WIDTH synchronous FIFO, AW+32 wide).
//   It has full/empty outputs and a flush input.
// TESTING
// - mem[0..3]=11,20,52,11; mem[4..7]=21,04,11,00 (hex); enable, ready=1 ->
//   inst 0x11522011 at pc 0, then 0x00110421 at pc 4.
// - inst_ready=0 with the same image -> exactly FIFO_D words buffered, mem_req then stays 0.
//   Raising ready drains them in order.
// - Redirect to 0x0004 while in WAIT on byte 2 of the word at pc 0 -> late byte discarded.
//   The first inst is then 0x00110421 at pc 4.
// - Redirect to 0x0006 -> fault=1, no mem_req. Then redirect to 0x0000 -> fault=0, fetch resumes.
// - PC = 2**AW-4 -> after that word, the next fetch is at address 0.
//   Also toggle enable mid-word: the word completes, then fetch stops.
// - Assert rst during WAIT with a random mem latency of 1-5 -> all outputs at reset values
//   immediately. The first word after release comes from RESET_PC.

Source files
------------

// File: rtl/ifetch_byte_reader_pkg.sv
// rtl/ifetch_byte_reader_pkg.sv - shared fetch-core types: instruction width, field layout, fetch FSM states
package ifetch_byte_reader_pkg;

  localparam int INST_W = 32;

  // Decoder view of an assembled word, MSB first.
  typedef struct packed {
    logic [11:0] imm12;
    logic [3:0]  func;
    logic [5:0]  rs;
    logic [5:0]  rd;
    logic [3:0]  cls;
  } inst_fields_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HALT
  } fetch_state_t;

endpackage

// File: rtl/ifetch_byte_reader_fifo.sv
// rtl/ifetch_byte_reader_fifo.sv - small synchronous FIFO with flush, holding {pc, inst} entries
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero before the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_byte_reader.sv
// rtl/ifetch_byte_reader.sv - per-thread fetch front end assembling 32-bit words from a byte-wide memory port
module ifetch_byte_reader
  import ifetch_byte_reader_pkg::*;
#(
  parameter int            AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter int            FIFO_D   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              redir_valid,
  input  logic [AW-1:0]     redir_pc,
  output logic              mem_req,
  output logic [AW-1:0]     mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_word,
  output logic [AW-1:0]     inst_pc,
  output logic              fault
);

  fetch_state_t         state;
  logic [AW-1:0]        pc;
  logic [1:0]           cnt;
  logic [23:0]          lanes;
  logic                 discard;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [AW+INST_W-1:0] push_data;
  logic [AW+INST_W-1:0] head;

  assign push       = (state == ST_WAIT) && mem_rvalid && (cnt == 2'd3) && !redir_valid;
  assign pop        = !empty && inst_ready && !redir_valid;
  assign push_data  = {pc, mem_rdata, lanes};
  assign inst_valid = !empty;
  assign inst_pc    = head[AW+INST_W-1 -: AW];
  assign inst_word  = head[INST_W-1:0];

  ifetch_fifo #(
    .DEPTH(FIFO_D),
    .WIDTH(AW + INST_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redir_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      pc       <= RESET_PC;
      cnt      <= '0;
      lanes    <= '0;
      discard  <= 1'b0;
      fault    <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else if (redir_valid) begin
      pc       <= redir_pc;
      cnt      <= '0;
      mem_req  <= 1'b0;
      mem_addr <= redir_pc;
      // A byte still owed by memory must be swallowed before the next request goes out.
      discard  <= ((state == ST_WAIT) && !mem_rvalid) ||
                  ((state == ST_REQ) && mem_gnt) ||
                  (discard && !mem_rvalid);
      if (redir_pc[1:0] != 2'b00) begin
        fault <= 1'b1;
        state <= ST_HALT;
      end else begin
        fault <= 1'b0;
        state <= ST_IDLE;
      end
    end else begin
      if (discard && mem_rvalid) discard <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable && !full && !fault && !discard) begin
            state    <= ST_REQ;
            mem_req  <= 1'b1;
            mem_addr <= pc;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            state   <= ST_WAIT;
            mem_req <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            if (cnt == 2'd3) begin
              pc    <= pc + AW'(4);
              cnt   <= '0;
              state <= ST_IDLE;
            end else begin
              case (cnt)
                2'd0:    lanes[7:0]   <= mem_rdata;
                2'd1:    lanes[15:8]  <= mem_rdata;
                default: lanes[23:16] <= mem_rdata;
              endcase
              cnt      <= cnt + 2'd1;
              state    <= ST_REQ;
              mem_req  <= 1'b1;
              mem_addr <= pc + AW'(cnt) + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
